tmr_regfile: RTL
================

# tmr_regfile

Triple-modular-redundant replacement for the processor's three-ported register file. It sits directly upstream of the redundant ALU and supplies its `a`/`b` operands. Three copies of registers 1..31 are stored, and every read bit is majority-voted. A background scrubber walks the array during cycles with no write, rewriting the voted value into all copies and counting the mismatches it repairs. A fault-injection port lets benches corrupt single copies.

## Interface
- `ERRW`, default 8: width of the saturating error counter.

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state (see Operation).
- `we3` in 1: write enable.
- `ra1`, `ra2` in 5: read addresses.
- `wa3` in 5: write address.
- `wd3` in 32: write data.
- `rd1`, `rd2` out 32: voted read data, combinational.
- `inj_en` in 1: fault-injection strobe.
- `inj_copy` in 2: target copy, 0..2; value 3 ignored.
- `inj_addr` in 5: target register; 0 ignored.
- `inj_bit` in 5: bit to flip.
- `err_clr` in 1: clears `err_flag` and `err_count`.
- `ready` out 1: high once init sweep is complete.
- `err_flag` out 1: sticky, set on any scrub-detected mismatch.
- `err_count` out ERRW: saturating count of scrub-detected mismatching words.
- `scrub_ptr` out 5: next address the scrubber visits, 1..31.

## Operation
- **Reset values:** `ready`=0, `err_flag`=0, `err_count`=0, `scrub_ptr`=1, FSM=INIT, init pointer=1. Array contents are not reset directly; the INIT sweep clears them.
- **FSM, two states:**
  - **INIT:** each cycle writes 0 to all three copies at the init pointer, then increments it. After writing address 31, go to SCRUB and set `ready`=1.
  - While in INIT: `we3` and `inj_en` are ignored, and `rd1`/`rd2` are forced to 0.
  - **SCRUB:** terminal state until reset.
- **Reads:** `rdN` = 0 if `raN`==0. Otherwise `rdN` = bitwise majority (a&b | a&c | b&c) of the three copies at `raN`.
- **Write** (SCRUB state, `we3`=1, `wa3`!=0): `wd3` is written to all three copies. Writes with `wa3`==0 are discarded.
- **Scrub cycle** (SCRUB state, `we3`=0):
  - Write the voted word at `scrub_ptr` into all three copies.
  - If the three copies at `scrub_ptr` were not all identical before the edge: set `err_flag`, and increment `err_count` unless it is at all-ones.
  - Advance `scrub_ptr`: 31 wraps to 1.
- **Scrubber stall:** when `we3`=1, `scrub_ptr` holds and no detection occurs. Scrub therefore never competes with the functional write port.
- **Injection** (SCRUB state, `inj_en`=1, `inj_copy`<3, `inj_addr`!=0): copy `inj_copy` at `inj_addr` receives its next value XOR (1<<`inj_bit`).
  - The next value is: `wd3` if the same cycle writes that address; else the voted word if the same cycle scrubs that address; else the current contents.
  - So injection always lands after the write or scrub.
- **`err_clr`:** zeroes `err_flag` and `err_count` at the edge. It takes priority over a same-cycle increment.
- **Double-copy fault:** two copies flipped at the same bit before a scrub visit produce an erroneous voted value. This is the documented limit of TMR: the scrubber makes the copies consistent with the wrong value and counts one error.
- **Reset mid-operation:** asynchronously returns to INIT. All contents are re-cleared over 31 cycles.

## Timing
- Read latency: 0 cycles, combinational from `raN` and the array.
- Write-to-read latency: 1 edge. A write at edge N is visible on `rdN` after edge N; there is no write-through bypass within the same cycle.
- Init: `ready` rises at the 31st rising edge after `reset` deasserts.
- Scrub sweep: 31 consecutive write-free cycles. A single-copy fault is repaired within ≤31 write-free cycles.
- `err_flag`/`err_count` update on the same edge as the correcting write.

## Test plan
- **Reset and init:** pulse `reset`, then count edges. Required: `ready`=0 for edges 1..30 and 1 after edge 31; `rd1` with `ra1`=5 reads 0; `scrub_ptr`=1 at `ready` rise.
- **Write/read:** write r3=0xDEADBEEF, then read `ra1`=3 → 0xDEADBEEF. Write `wa3`=0 with 0x1234, then read `ra2`=0 → 0.
- **Single-copy repair:** write r7=0x10, inject copy 1, r7, bit 4. Required: `rd1`(r7) stays 0x10; within 31 idle cycles `err_count`=1 and `err_flag`=1; a further 31 idle cycles leave `err_count`=1.
- **Double-copy fault:** r9=0, inject copies 0 and 2, bit 0 → `rd1`(r9)=0x1. After a sweep, all copies = 0x1 and `err_count` += 1.
- **Scrub stall:** hold `we3`=1 for 100 cycles. Required: `scrub_ptr` constant and `err_count` unchanged.
- **Saturation and reset:** with `ERRW`=2, perform five separate single-copy repairs → `err_count`=3 and `err_flag`=1. Then assert `err_clr` → both 0. Assert `reset` mid-INIT → `ready` rises 31 edges after release.

Source files
------------

// File: rtl/tmr_regfile_if.sv
// Operand/write/fault-injection/status bundle between the core and its TMR register file.
// Latency: none of its own; it only groups wires.
// Backpressure: none; the register file accepts a write or an injection every cycle.
interface tmr_regfile_if #(
    parameter int ERRW = 8
);
    logic            we3;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [4:0]      wa3;
    logic [31:0]     wd3;
    logic [31:0]     rd1;
    logic [31:0]     rd2;
    logic            inj_en;
    logic [1:0]      inj_copy;
    logic [4:0]      inj_addr;
    logic [4:0]      inj_bit;
    logic            err_clr;
    logic            ready;
    logic            err_flag;
    logic [ERRW-1:0] err_count;
    logic [4:0]      scrub_ptr;

    // Core or bench side: drives addresses, write data and injection; observes reads and status.
    modport master (
        output we3, ra1, ra2, wa3, wd3,
        output inj_en, inj_copy, inj_addr, inj_bit, err_clr,
        input  rd1, rd2, ready, err_flag, err_count, scrub_ptr
    );

    // Register file side.
    modport slave (
        input  we3, ra1, ra2, wa3, wd3,
        input  inj_en, inj_copy, inj_addr, inj_bit, err_clr,
        output rd1, rd2, ready, err_flag, err_count, scrub_ptr
    );
endinterface

// File: rtl/tmr_regfile.sv
// Three-copy register file (r1..r31) with majority-voted reads, a background scrubber and a fault-injection port.
// Latency: reads are combinational; a write is visible after one edge; the init sweep takes 31 edges.
// Backpressure: none; a write stalls the scrubber for that cycle and never waits itself.
module tmr_regfile #(
    parameter int ERRW = 8
) (
    input  logic          clk,
    input  logic          reset,
    tmr_regfile_if.slave  bus
);
    typedef enum logic {INIT, SCRUB} state_t;

    state_t          state_q, state_d;
    logic [4:0]      init_ptr_q, init_ptr_d;
    logic [4:0]      scrub_ptr_q, scrub_ptr_d;
    logic            err_flag_q, err_flag_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    // Copy c, register a. Entry 0 is never written or read.
    logic [31:0] mem [3][32];

    // Primary array update this cycle: the init clear, a functional write, or a scrub rewrite.
    logic        prim_en;
    logic [4:0]  prim_addr;
    logic [31:0] prim_data;
    logic [31:0] scrub_vote;
    logic        scrub_mis;
    logic        inj_ok;
    logic [31:0] inj_cur;
    logic [31:0] inj_val;

    function automatic logic [31:0] vote(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Voted read ports; address 0 and the whole init sweep read as zero.
    always_comb begin
        bus.rd1 = '0;
        bus.rd2 = '0;
        if (state_q == SCRUB && bus.ra1 != 5'd0)
            bus.rd1 = vote(mem[0][bus.ra1], mem[1][bus.ra1], mem[2][bus.ra1]);
        if (state_q == SCRUB && bus.ra2 != 5'd0)
            bus.rd2 = vote(mem[0][bus.ra2], mem[1][bus.ra2], mem[2][bus.ra2]);
    end

    // Next-state, primary array update, scrub detection and error counter update.
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        scrub_ptr_d = scrub_ptr_q;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        prim_en     = 1'b0;
        prim_addr   = init_ptr_q;
        prim_data   = '0;
        scrub_mis   = 1'b0;
        scrub_vote  = vote(mem[0][scrub_ptr_q], mem[1][scrub_ptr_q], mem[2][scrub_ptr_q]);

        case (state_q)
            INIT: begin
                prim_en    = 1'b1;
                prim_addr  = init_ptr_q;
                prim_data  = '0;
                init_ptr_d = init_ptr_q + 5'd1;
                if (init_ptr_q == 5'd31)
                    state_d = SCRUB;
            end
            SCRUB: begin
                if (bus.we3) begin
                    // Functional write owns the array this cycle; the scrubber holds.
                    prim_en   = (bus.wa3 != 5'd0);
                    prim_addr = bus.wa3;
                    prim_data = bus.wd3;
                end else begin
                    prim_en     = 1'b1;
                    prim_addr   = scrub_ptr_q;
                    prim_data   = scrub_vote;
                    scrub_mis   = !((mem[0][scrub_ptr_q] == mem[1][scrub_ptr_q]) &&
                                    (mem[1][scrub_ptr_q] == mem[2][scrub_ptr_q]));
                    scrub_ptr_d = (scrub_ptr_q == 5'd31) ? 5'd1 : scrub_ptr_q + 5'd1;
                end
            end
            default: state_d = INIT;
        endcase

        if (scrub_mis) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != {ERRW{1'b1}})
                err_cnt_d = err_cnt_q + 1'b1;
        end
        // Clear wins over a same-cycle detection.
        if (bus.err_clr) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    // Injection flips one bit of whatever the target copy would hold after this edge.
    always_comb begin
        inj_ok = (state_q == SCRUB) && bus.inj_en && (bus.inj_copy != 2'd3) && (bus.inj_addr != 5'd0);
        case (bus.inj_copy)
            2'd1:    inj_cur = mem[1][bus.inj_addr];
            2'd2:    inj_cur = mem[2][bus.inj_addr];
            default: inj_cur = mem[0][bus.inj_addr];
        endcase
        inj_val = ((prim_en && prim_addr == bus.inj_addr) ? prim_data : inj_cur) ^ (32'd1 << bus.inj_bit);
    end

    // Control state: FSM, pointers and error status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            init_ptr_q  <= 5'd1;
            scrub_ptr_q <= 5'd1;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            scrub_ptr_q <= scrub_ptr_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Array storage; the injection assignment comes last so it overrides the primary update.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (prim_en)
                mem[c][prim_addr] <= prim_data;
            if (inj_ok && bus.inj_copy == 2'(c))
                mem[c][bus.inj_addr] <= inj_val;
        end
    end

    assign bus.ready     = (state_q == SCRUB);
    assign bus.err_flag  = err_flag_q;
    assign bus.err_count = err_cnt_q;
    assign bus.scrub_ptr = scrub_ptr_q;
endmodule
